// File: rtl/wb_line_fetch_master.sv
// Wishbone classic read master that streams a block of consecutive words into an FWFT FIFO.
// Latency: first strobe 2 cycles after an accepted start; one access outstanding, idle cycle between accesses.
// Backpressure: no request is issued while the FIFO is full; fetching resumes as rd_en_i frees space.
// Optional ack watchdog: define WB_TIMEOUT_EN.

// Generic first-word-fall-through FIFO; head word is visible on rd_data while not empty.
// Latency: a write is visible at the head one cycle later.
// Backpressure: the writer must respect full; pops while empty are ignored.
module wb_line_fetch_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset: contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

module wb_line_fetch_master #(
    parameter int ADDR_W         = 24,
    parameter int DATA_W         = 16,
    parameter int LEN_W          = 10,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          start_i,
    input  logic [ADDR_W-1:0]             start_addr_i,
    input  logic [LEN_W-1:0]              len_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o,
    output logic                          wb_cyc_o,
    output logic                          wb_stb_o,
    output logic                          wb_we_o,
    output logic [ADDR_W-1:0]             wb_adr_o,
    output logic [1:0]                    wb_sel_o,
    input  logic                          wb_ack_i,
    input  logic [DATA_W-1:0]             wb_dat_i,
    input  logic                          rd_en_i,
    output logic [DATA_W-1:0]             rd_data_o,
    output logic                          fifo_empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [LEN_W-1:0]  remaining_q;
    logic [LEN_W-1:0]  remaining_d;
    logic              fifo_push;
    logic              fifo_full;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("wb_line_fetch_master: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    // Bus strobes come straight from the state register so reset removes them asynchronously.
    assign wb_cyc_o = (state_q == WAIT_ACK);
    assign wb_stb_o = (state_q == WAIT_ACK);
    assign wb_we_o  = 1'b0;
    assign wb_sel_o = 2'b11;
    assign wb_adr_o = addr_q;
    assign busy_o   = (state_q == REQ) || (state_q == WAIT_ACK);
    assign done_o   = (state_q == DONE);

`ifdef WB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             err_q;
    logic             err_d;
    logic             tmo_hit;

    assign tmo_hit = (state_q == WAIT_ACK) && !wb_ack_i &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign err_o   = err_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= err_d;
            if (state_q == WAIT_ACK) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end else begin
                tmo_cnt_q <= '0;
            end
        end
    end
`else
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        fifo_push   = 1'b0;
`ifdef WB_TIMEOUT_EN
        err_d       = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
`ifdef WB_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                    if (len_i != '0) begin
                        addr_d      = start_addr_i;
                        remaining_d = len_i;
                        state_d     = REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                if (!fifo_full) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // Only one access is ever outstanding and REQ checked for space, so the push always fits.
                if (wb_ack_i) begin
                    fifo_push   = 1'b1;
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    state_d     = (remaining_q == LEN_W'(1)) ? DONE : REQ;
                end
`ifdef WB_TIMEOUT_EN
                else if (tmo_hit) begin
                    err_d       = 1'b1;
                    remaining_d = '0;
                    state_d     = DONE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    wb_line_fetch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .wr_en   (fifo_push),
        .wr_data (wb_dat_i),
        .rd_en   (rd_en_i),
        .rd_data (rd_data_o),
        .empty   (fifo_empty_o),
        .full    (fifo_full),
        .level   (fifo_level_o)
    );
endmodule

// File: doc/wb_line_fetch_master.md
Name: wb_line_fetch_master

Overview:
- Wishbone classic master that reads a block of consecutive 16-bit words from SDRAM through the SDRAM Wishbone controller.
- Places the words in a small first-word-fall-through (FWFT) FIFO for a downstream consumer (video line buffer, DMA sink).
- It is the initiator side of the bus that the SDRAM controller serves as responder.
- One outstanding access at a time; fetches stall when the FIFO is full.

Parameters:
ADDR_W, 24, Wishbone word address width
DATA_W, 16, Wishbone data width
LEN_W, 10, width of transfer length (max 2^LEN_W-1 words)
FIFO_DEPTH, 16, FIFO entries (power of two, >= 2)
TIMEOUT_CYCLES, 255, ack watchdog limit (used only with WB_TIMEOUT_EN)

Ports:
wb_clk_i  in  1  single clock, all logic rising-edge
wb_rst_i  in  1  asynchronous, active-high reset
start_i  in  1  one-cycle request to begin a block fetch
start_addr_i  in  ADDR_W  first word address, sampled with start_i
len_i  in  LEN_W  word count, sampled with start_i
busy_o  out  1  block fetch in progress
done_o  out  1  one-cycle pulse when the block completes or aborts
err_o  out  1  sticky timeout flag, cleared by the next accepted start_i
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  constant 0 (read-only master)
wb_adr_o  out  ADDR_W  Wishbone address
wb_sel_o  out  2  constant 2'b11
wb_ack_i  in  1  Wishbone acknowledge
wb_dat_i  in  DATA_W  Wishbone read data
rd_en_i  in  1  pop FIFO head
rd_data_o  out  DATA_W  FIFO head word (FWFT)
fifo_empty_o  out  1  FIFO empty
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values:
  - busy_o, done_o, err_o, wb_cyc_o, wb_stb_o = 0; wb_adr_o = 0.
  - FIFO empty: fifo_empty_o = 1, fifo_level_o = 0; rd_data_o undefined/don't-care.
  - State = IDLE.
- Reset mid-fetch: all of the above apply immediately (async); buffered data is discarded.
- States:
  - IDLE: start_i with len_i != 0 latches address and remaining = len_i, clears err_o, sets busy_o, goes to REQ. start_i with len_i == 0 goes to DONE, with no bus activity.
  - REQ: if FIFO not full, drive cyc = stb = 1 and wb_adr_o = current address next cycle, go to WAIT_ACK. Otherwise stay in REQ with cyc = stb = 0.
  - WAIT_ACK: hold cyc, stb and address stable until wb_ack_i.
    - On ack: write wb_dat_i into FIFO the same edge, drop cyc/stb the next cycle, address += 1 (wraps modulo 2^ADDR_W), remaining -= 1.
    - remaining reaching 0 goes to DONE, else REQ. At least one idle bus cycle separates consecutive accesses.
  - DONE: done_o = 1 for exactly one cycle, busy_o = 0, then IDLE.
- start_i while busy_o = 1 is ignored.
- Latency: first wb_stb_o rises 2 cycles after accepted start_i if the FIFO has space.
- FIFO rules:
  - Full means level == FIFO_DEPTH; no request is issued while full. Since at most one access is outstanding, an ack always finds space.
  - Simultaneous write and pop: level unchanged, data ordering preserved.
  - rd_en_i while empty: ignored, level stays 0.
  - Pointers wrap modulo FIFO_DEPTH.
  - FIFO contents persist across blocks; a new start does not flush.
- wb_ack_i outside WAIT_ACK is ignored.

Optional Feature:
- Macro WB_TIMEOUT_EN.
- Defined: a counter runs in WAIT_ACK. If TIMEOUT_CYCLES cycles pass without ack, the master drops cyc/stb, sets err_o, discards the remaining count, goes to DONE (done_o pulses) and writes nothing for that access.
- Undefined: no counter, WAIT_ACK waits indefinitely, err_o is tied to 0.

Test Plan:
- Basic fetch: start addr 0x000100, len 4; responder returns 0xA000..0xA003 -> four single accesses at 0x100..0x103, each with a gap cycle; FIFO pops 0xA000..0xA003 in order; one done_o pulse; busy_o low after.
- Backpressure: FIFO_DEPTH 16, len 20, no pops -> stb stops after 16 acks with level = 16. Pop 1 -> exactly one new access issued; finish by popping -> all 20 words correct.
- Address wrap and zero length: start 0xFFFFFE, len 3 -> addresses 0xFFFFFE, 0xFFFFFF, 0x000000. Separately, len 0 -> done_o the cycle after DONE entry, cyc never asserted.
- Simultaneous ack and pop with level 5 -> level stays 5. start_i pulsed mid-fetch -> ignored, address sequence unchanged.
- Reset mid-access: assert wb_rst_i while in WAIT_ACK -> cyc/stb/busy drop the same cycle (async), level 0, next start behaves as from power-up.
- With WB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, responder never acks -> cyc drops after 8 cycles, err_o = 1, done_o pulses, level unchanged. Next start clears err_o.
